// File: rtl/encoder_sampler.sv
// rtl/encoder_sampler.sv - periodic encoder snapshot forming absolute position and velocity
// Samples every SAMPLE_DIV cycles through a CAP/CALC/OUT pipeline; results held behind a valid/ack handshake.
module encoder_sampler #(
    parameter int SAMPLE_DIV = 50000,
    parameter int ENCO_NUM   = 4000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic signed [15:0] motor_cnt,
    input  logic signed [15:0] motor_cir,
    input  logic        [1:0]  motor_dir,
    input  logic               rd_ack,
    output logic               samp_valid,
    output logic signed [31:0] samp_pos,
    output logic signed [31:0] samp_vel,
    output logic        [1:0]  samp_dir,
    output logic               samp_ovr,
    output logic               busy
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CAP, S_CALC, S_OUT} state_t;

    localparam logic        [23:0] DIV_LAST = 24'(SAMPLE_DIV - 1);
    localparam logic signed [31:0] ENCO_W   = 32'(ENCO_NUM);

    state_t             state_q;
    logic        [23:0] tick_cnt_q;
    logic signed [15:0] cnt_l_q;
    logic signed [15:0] cir_l_q;
    logic        [1:0]  dir_l_q;
    logic signed [31:0] pos_r_q;
    logic signed [31:0] prev_pos_q;
    logic               first_q;
    logic               valid_q;
    logic               ovr_q;
    logic               busy_q;
    logic signed [31:0] pos_q;
    logic signed [31:0] vel_q;
    logic        [1:0]  sdir_q;

    logic               tick;
    logic        [23:0] tick_cnt_d;
    logic signed [31:0] cir_ext;
    logic signed [31:0] cnt_ext;
    logic signed [31:0] pos_d;
    logic signed [31:0] vel_d;

    always_comb begin
        tick       = (state_q != S_IDLE) && (tick_cnt_q == DIV_LAST);
        tick_cnt_d = tick ? 24'd0 : tick_cnt_q + 24'd1;
        cir_ext    = {{16{cir_l_q[15]}}, cir_l_q};
        cnt_ext    = {{16{cnt_l_q[15]}}, cnt_l_q};
        pos_d      = cir_ext * ENCO_W + cnt_ext;
        vel_d      = first_q ? 32'sd0 : pos_r_q - prev_pos_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            cnt_l_q    <= '0;
            cir_l_q    <= '0;
            dir_l_q    <= '0;
            pos_r_q    <= '0;
            prev_pos_q <= '0;
            first_q    <= 1'b1;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
            pos_q      <= '0;
            vel_q      <= '0;
            sdir_q     <= '0;
        end else if (!enable) begin
            // Data outputs deliberately keep their last values while idle.
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            first_q    <= 1'b1;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (state_q != S_IDLE) begin
                tick_cnt_q <= tick_cnt_d;
            end
            busy_q <= 1'b0;
            if (valid_q && rd_ack) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            case (state_q)
                S_IDLE: state_q <= S_RUN;
                S_RUN: begin
                    if (tick) begin
                        cnt_l_q <= motor_cnt;
                        cir_l_q <= motor_cir;
                        dir_l_q <= motor_dir;
                        busy_q  <= 1'b1;
                        state_q <= S_CAP;
                    end
                end
                S_CAP: begin
                    pos_r_q <= pos_d;
                    busy_q  <= 1'b1;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    busy_q  <= 1'b1;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    // A same-cycle ack consumes the old sample, so it cannot count as an overrun.
                    pos_q      <= pos_r_q;
                    vel_q      <= vel_d;
                    sdir_q     <= dir_l_q;
                    prev_pos_q <= pos_r_q;
                    first_q    <= 1'b0;
                    valid_q    <= 1'b1;
                    if (valid_q && !rd_ack) begin
                        ovr_q <= 1'b1;
                    end
                    state_q <= S_RUN;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign samp_valid = valid_q;
    assign samp_pos   = pos_q;
    assign samp_vel   = vel_q;
    assign samp_dir   = sdir_q;
    assign samp_ovr   = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_encoder_sampler.sv
// tb/tb_encoder_sampler.sv - self-checking bench for encoder_sampler
// Event-level reference: ticks at E+k*DIV, each result pending for four cycles, then handshake rules.
module tb_encoder_sampler;
    localparam int DIV = 16;
    localparam int ENC = 4000;

    logic        clk = 1'b0;
    logic        rst_n, enable, rd_ack;
    logic [15:0] motor_cnt, motor_cir;
    logic [1:0]  motor_dir;
    logic        samp_valid, samp_ovr, busy;
    logic [31:0] samp_pos, samp_vel;
    logic [1:0]  samp_dir;

    always #5 clk = ~clk;

    encoder_sampler #(.SAMPLE_DIV(DIV), .ENCO_NUM(ENC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .motor_cnt(motor_cnt), .motor_cir(motor_cir), .motor_dir(motor_dir),
        .rd_ack(rd_ack), .samp_valid(samp_valid), .samp_pos(samp_pos),
        .samp_vel(samp_vel), .samp_dir(samp_dir), .samp_ovr(samp_ovr), .busy(busy)
    );

    typedef struct {
        int          due;
        logic [31:0] pos;
        logic [1:0]  dir;
    } pend_t;

    pend_t       pq[$];
    logic        m_valid, m_ovr, m_first, m_idle;
    logic [31:0] m_pos, m_vel, m_prev;
    logic [1:0]  m_dir;
    int          e_cycle;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Applies the effect of the edge that ends cycle cyc, using that cycle's inputs.
    task automatic model_edge();
        pend_t p;
        bit    acked;
        if (!rst_n) begin
            pq.delete();
            m_valid = 0; m_ovr = 0; m_first = 1; m_idle = 1;
            m_pos = 0; m_vel = 0; m_prev = 0; m_dir = 0;
        end else if (!enable) begin
            pq.delete();
            m_valid = 0; m_ovr = 0; m_first = 1; m_idle = 1;
        end else begin
            acked = m_valid && rd_ack;
            if (m_idle) begin
                m_idle  = 0;
                e_cycle = cyc;
            end else if ((cyc - e_cycle) % DIV == 0) begin
                p.due = cyc + 4;
                p.pos = int'($signed(motor_cir)) * ENC + int'($signed(motor_cnt));
                p.dir = motor_dir;
                pq.push_back(p);
            end
            if (pq.size() > 0 && pq[0].due == cyc + 1) begin
                p       = pq.pop_front();
                m_vel   = m_first ? 32'd0 : p.pos - m_prev;
                m_prev  = p.pos;
                m_first = 0;
                m_pos   = p.pos;
                m_dir   = p.dir;
                if (m_valid && !rd_ack) m_ovr = 1;
                else if (acked) m_ovr = 0;
                m_valid = 1;
            end else if (acked) begin
                m_valid = 0;
                m_ovr   = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
        chk("valid", {31'd0, samp_valid}, {31'd0, m_valid});
        chk("ovr",   {31'd0, samp_ovr},   {31'd0, m_ovr});
        chk("busy",  {31'd0, busy},       {31'd0, pq.size() != 0});
        chk("pos",   samp_pos, m_pos);
        chk("vel",   samp_vel, m_vel);
        chk("dir",   {30'd0, samp_dir}, {30'd0, m_dir});
    endtask

    task automatic rand_motor();
        motor_cnt = 16'($urandom);
        motor_cir = 16'($urandom);
        motor_dir = 2'($urandom);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            rand_motor();
            step();
        end
    endtask

    int          e, r;
    logic [31:0] held_pos;

    initial begin
        cyc = 0;
        rst_n = 0; enable = 0; rd_ack = 0;
        rand_motor();
        m_valid = 0; m_ovr = 0; m_first = 1; m_idle = 1;
        m_pos = 0; m_vel = 0; m_prev = 0; m_dir = 0; e_cycle = 0;

        repeat (3) step();
        chk("rst_valid", {31'd0, samp_valid}, 32'd0);
        chk("rst_pos", samp_pos, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // First and second samples with handshake
        rst_n = 1; enable = 1; e = cyc;
        run_to(e + 16);
        motor_cnt = 16'd100; motor_cir = 16'd2; motor_dir = 2'b01;
        step();
        run_to(e + 19);
        chk("first_not_yet", {31'd0, samp_valid}, 32'd0);
        run_to(e + 20);
        chk("first_valid", {31'd0, samp_valid}, 32'd1);
        chk("first_pos", samp_pos, 32'd8100);
        chk("first_vel", samp_vel, 32'd0);
        run_to(e + 25);
        rd_ack = 1;
        step();
        chk("ack_clears", {31'd0, samp_valid}, 32'd0);
        run_to(e + 31);
        chk("ack_idle_noeffect", {31'd0, samp_valid}, 32'd0);
        rd_ack = 0;
        run_to(e + 32);
        motor_cnt = 16'hFFCE; motor_cir = 16'd2; motor_dir = 2'b10;
        step();
        run_to(e + 36);
        chk("second_pos", samp_pos, 32'd7950);
        chk("second_vel", samp_vel, 32'hFFFF_FF6A);
        chk("second_dir", {30'd0, samp_dir}, 32'd2);
        chk("second_ovr", {31'd0, samp_ovr}, 32'd0);

        // Overrun, then ack coinciding with OUT
        run_to(e + 52);
        chk("ovr_set", {31'd0, samp_ovr}, 32'd1);
        rd_ack = 1;
        step();
        rd_ack = 0;
        chk("ovr_ack_valid", {31'd0, samp_valid}, 32'd0);
        chk("ovr_ack_ovr", {31'd0, samp_ovr}, 32'd0);
        run_to(e + 84);
        chk("ovr_again", {31'd0, samp_ovr}, 32'd1);
        run_to(e + 99);
        rd_ack = 1;
        step();
        rd_ack = 0;
        chk("same_cycle_valid", {31'd0, samp_valid}, 32'd1);
        chk("same_cycle_ovr", {31'd0, samp_ovr}, 32'd0);

        // Disable in CALC, re-enable
        run_to(e + 114);
        held_pos = m_pos;
        enable = 0;
        step();
        chk("dis_busy", {31'd0, busy}, 32'd0);
        chk("dis_valid", {31'd0, samp_valid}, 32'd0);
        chk("dis_pos_hold", samp_pos, held_pos);
        run_to(cyc + 2);
        enable = 1; r = cyc;
        run_to(r + 20);
        chk("reen_valid", {31'd0, samp_valid}, 32'd1);
        chk("reen_vel", samp_vel, 32'd0);

        // Reset mid-RUN
        run_to(r + 30);
        rst_n = 0;
        run_to(cyc + 3);
        chk("midrst_pos", samp_pos, 32'd0);
        chk("midrst_vel", samp_vel, 32'd0);
        chk("midrst_valid", {31'd0, samp_valid}, 32'd0);
        rst_n = 1; r = cyc;
        run_to(r + 19);
        chk("midrst_wait", {31'd0, samp_valid}, 32'd0);
        run_to(r + 20);
        chk("midrst_first", {31'd0, samp_valid}, 32'd1);

        // Randomized traffic against the reference
        for (int i = 0; i < 900; i++) begin
            rd_ack = ($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 119) != 0);
            rst_n  = ($urandom_range(0, 299) != 0);
            rand_motor();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
